// File: rtl/vx_tcu_uop_seq_pkg.sv
// Purpose : shared TCU constants (sub-block geometry, step-field width) and the
//           micro-op sequencer state type.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package vx_tcu_uop_seq_pkg;

    // Tensor-core tiling: an MMA instruction is split across the A (rows) and
    // B (columns) sub-blocks. Each sub-block pairing is one micro-op.
    localparam int TCU_A_SUB_BLOCKS = 2;
    localparam int TCU_B_SUB_BLOCKS = 2;

    // Step indices travel to the FP execute stage in a fixed 4-bit field,
    // which caps either dimension at 16 steps.
    localparam int TCU_STEP_W  = 4;
    localparam int TCU_M_STEPS = TCU_A_SUB_BLOCKS;
    localparam int TCU_N_STEPS = TCU_B_SUB_BLOCKS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_e;

endpackage

// File: rtl/vx_tcu_uop_seq.sv
// Purpose : expands one TCU MMA instruction into M_STEPS*N_STEPS micro-ops,
//           step_m inner loop and step_n outer loop, each tagged with sop/eop.
// Latency : first micro-op is presented 1 cycle after the instruction is accepted;
//           back-to-back instructions follow each other with no bubble.
// Backpressure: valid/ready on both sides; outputs hold while out_ready is low,
//           and a new instruction is taken only when idle or on the last micro-op.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   in_valid/in_ready     - instruction handshake, in_data is the opaque payload
//   out_valid/out_ready   - micro-op handshake toward the FP execute stage
//   out_data              - payload of the instruction being expanded
//   out_step_m/out_step_n - current step indices
//   out_sop/out_eop       - first / last micro-op of the instruction
//   busy                  - an instruction is in flight
//   perf_instrs/perf_uops/perf_stalls - wrapping event counters, present only
//                           when the TCU_UOP_PERF_EN macro is defined
module vx_tcu_uop_seq
    import vx_tcu_uop_seq_pkg::*;
#(
    parameter int M_STEPS = TCU_M_STEPS,
    parameter int N_STEPS = TCU_N_STEPS,
    parameter int DATAW   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATAW-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATAW-1:0]      out_data,
    output logic [TCU_STEP_W-1:0] out_step_m,
    output logic [TCU_STEP_W-1:0] out_step_n,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready,
    output logic                  busy
`ifdef TCU_UOP_PERF_EN
    ,
    output logic [31:0]           perf_instrs,
    output logic [31:0]           perf_uops,
    output logic [31:0]           perf_stalls
`endif
);

    localparam logic [TCU_STEP_W-1:0] M_LAST = TCU_STEP_W'(M_STEPS - 1);
    localparam logic [TCU_STEP_W-1:0] N_LAST = TCU_STEP_W'(N_STEPS - 1);

    seq_state_e            state_q, state_d;
    logic [TCU_STEP_W-1:0] step_m_q, step_m_d;
    logic [TCU_STEP_W-1:0] step_n_q, step_n_d;
    logic [DATAW-1:0]      data_q, data_d;

    logic is_last;
    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            step_m_q <= '0;
            step_n_q <= '0;
        end else begin
            state_q  <= state_d;
            step_m_q <= step_m_d;
            step_n_q <= step_n_d;
        end
    end

    // The payload is only meaningful while a micro-op is valid, so it carries
    // no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A new instruction taken on the last micro-op keeps us issuing.
                if (in_fire)                  state_d = ST_ISSUE;
                else if (out_fire && is_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Step counters and payload. Counters return to zero after the last
    // micro-op so an idle sequencer always reads (0,0).
    always_comb begin
        step_m_d = step_m_q;
        step_n_d = step_n_q;
        data_d   = data_q;
        if (in_fire) begin
            step_m_d = '0;
            step_n_d = '0;
            data_d   = in_data;
        end else if (out_fire) begin
            if (is_last) begin
                step_m_d = '0;
                step_n_d = '0;
            end else if (step_m_q == M_LAST) begin
                step_m_d = '0;
                step_n_d = step_n_q + 1'b1;
            end else begin
                step_m_d = step_m_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q == ST_ISSUE);
        busy      = (state_q == ST_ISSUE);
        is_last   = (step_m_q == M_LAST) && (step_n_q == N_LAST);
        out_sop   = out_valid && (step_m_q == '0) && (step_n_q == '0);
        out_eop   = out_valid && is_last;
        in_ready  = (state_q == ST_IDLE) || (out_valid && out_ready && out_eop);
    end

    assign out_data   = data_q;
    assign out_step_m = step_m_q;
    assign out_step_n = step_n_q;

`ifdef TCU_UOP_PERF_EN
    logic [31:0] perf_instrs_q, perf_instrs_d;
    logic [31:0] perf_uops_q,   perf_uops_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_instrs_d = perf_instrs_q + {31'b0, in_fire};
        perf_uops_d   = perf_uops_q   + {31'b0, out_fire};
        perf_stalls_d = perf_stalls_q + {31'b0, (out_valid && !out_ready)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instrs_q <= '0;
            perf_uops_q   <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_instrs_q <= perf_instrs_d;
            perf_uops_q   <= perf_uops_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_instrs = perf_instrs_q;
    assign perf_uops   = perf_uops_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_tcu_uop_seq.sv
// Bench for vx_tcu_uop_seq: three instances (2x2, 1x1, 16x16) checked every
// cycle against an index-based model of the micro-op stream, plus directed
// scenarios with hand-computed expectations.
module tb_vx_tcu_uop_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [3];
    logic        in_valid   [3];
    logic [63:0] in_data    [3];
    logic        in_ready   [3];
    logic        out_valid  [3];
    logic [63:0] out_data   [3];
    logic [3:0]  out_step_m [3];
    logic [3:0]  out_step_n [3];
    logic        out_sop    [3];
    logic        out_eop    [3];
    logic        out_ready  [3];
    logic        busy       [3];
`ifdef TCU_UOP_PERF_EN
    logic [31:0] perf_instrs [3];
    logic [31:0] perf_uops   [3];
    logic [31:0] perf_stalls [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GM = (g == 0) ? 2 : ((g == 1) ? 1 : 16);
        vx_tcu_uop_seq #(.M_STEPS(GM), .N_STEPS(GM), .DATAW(64)) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .in_valid   (in_valid[g]),
            .in_data    (in_data[g]),
            .in_ready   (in_ready[g]),
            .out_valid  (out_valid[g]),
            .out_data   (out_data[g]),
            .out_step_m (out_step_m[g]),
            .out_step_n (out_step_n[g]),
            .out_sop    (out_sop[g]),
            .out_eop    (out_eop[g]),
            .out_ready  (out_ready[g]),
            .busy       (busy[g])
`ifdef TCU_UOP_PERF_EN
            ,
            .perf_instrs(perf_instrs[g]),
            .perf_uops  (perf_uops[g]),
            .perf_stalls(perf_stalls[g])
`endif
        );
    end

    function automatic int steps(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 16);
    endfunction

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: an instruction is a linear run of micro-op indices 0..M*N-1.
    bit          m_act    [3];
    int          m_idx    [3];
    logic [63:0] m_dat    [3];
    int          m_instrs [3];
    int          m_uops   [3];
    int          m_stalls [3];
    bit          started = 1'b0;

    // Observed-event counters and a fire log of instance 0.
    int          fires     [3];
    int          in_fires  [3];
    int          stall_obs [3];
    int          lg_cyc [$];
    logic [63:0] lg_dat [$];
    int          lg_m   [$];
    int          lg_n   [$];
    bit          lg_sop [$];
    bit          lg_eop [$];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_idx[i] = 0; m_dat[i] = '0;
            m_instrs[i] = 0; m_uops[i] = 0; m_stalls[i] = 0;
            fires[i] = 0; in_fires[i] = 0; stall_obs[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int tot    = steps(i) * steps(i);
            automatic bit exp_ir = !m_act[i] || (out_ready[i] && (m_idx[i] == tot - 1));
            automatic int em     = m_idx[i] % steps(i);
            automatic int en     = m_idx[i] / steps(i);
            if (started) begin
                chk($sformatf("d%0d out_valid", i), 64'(out_valid[i]), 64'(m_act[i]));
                chk($sformatf("d%0d busy", i),      64'(busy[i]),      64'(m_act[i]));
                chk($sformatf("d%0d in_ready", i),  64'(in_ready[i]),  64'(exp_ir));
                chk($sformatf("d%0d sop", i), 64'(out_sop[i]), 64'(m_act[i] && m_idx[i] == 0));
                chk($sformatf("d%0d eop", i), 64'(out_eop[i]), 64'(m_act[i] && m_idx[i] == tot - 1));
                chk($sformatf("d%0d step_m", i), 64'(out_step_m[i]), 64'(em));
                chk($sformatf("d%0d step_n", i), 64'(out_step_n[i]), 64'(en));
                if (m_act[i]) chk($sformatf("d%0d data", i), out_data[i], m_dat[i]);
`ifdef TCU_UOP_PERF_EN
                chk($sformatf("d%0d perf_instrs", i), 64'(perf_instrs[i]), 64'(32'(m_instrs[i])));
                chk($sformatf("d%0d perf_uops", i),   64'(perf_uops[i]),   64'(32'(m_uops[i])));
                chk($sformatf("d%0d perf_stalls", i), 64'(perf_stalls[i]), 64'(32'(m_stalls[i])));
`endif
            end
            if (out_valid[i] && out_ready[i]) begin
                fires[i]++;
                if (i == 0) begin
                    lg_cyc.push_back(cyc);
                    lg_dat.push_back(out_data[0]);
                    lg_m.push_back(int'(out_step_m[0]));
                    lg_n.push_back(int'(out_step_n[0]));
                    lg_sop.push_back(out_sop[0]);
                    lg_eop.push_back(out_eop[0]);
                end
            end
            if (in_valid[i] && in_ready[i]) in_fires[i]++;
            if (out_valid[i] && !out_ready[i]) stall_obs[i]++;

            if (reset[i]) begin
                m_act[i] = 0; m_idx[i] = 0;
                m_instrs[i] = 0; m_uops[i] = 0; m_stalls[i] = 0;
            end else begin
                if (m_act[i] && !out_ready[i]) m_stalls[i]++;
                if (m_act[i] && out_ready[i])  m_uops[i]++;
                if (in_valid[i] && exp_ir) begin
                    m_instrs[i]++;
                    m_act[i] = 1; m_idx[i] = 0; m_dat[i] = in_data[i];
                end else if (m_act[i] && out_ready[i]) begin
                    if (m_idx[i] == tot - 1) begin
                        m_act[i] = 0; m_idx[i] = 0;
                    end else begin
                        m_idx[i]++;
                    end
                end
            end
        end
        if (reset[0]) started = 1'b1;
        cyc++;
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        lg_cyc.delete(); lg_dat.delete(); lg_m.delete();
        lg_n.delete(); lg_sop.delete(); lg_eop.delete();
    endtask

    task automatic wait_log(input int n, input string nm);
        int b;
        b = 0;
        while (lg_m.size() < n && b < 200) begin
            step();
            b++;
        end
        chk({nm, " in time"}, 64'(b < 200), 64'd1);
    endtask

    initial begin
        int c0, base, s0, f0, lows, b;
`ifdef TCU_UOP_PERF_EN
        logic [31:0] p0;
`endif
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1; in_valid[i] = 0; in_data[i] = '0; out_ready[i] = 1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) reset[i] = 0;
        step();
        chk("reset in_ready", 64'(in_ready[0]), 64'd1);
        chk("reset out_valid", 64'(out_valid[0]), 64'd0);
        chk("reset busy", 64'(busy[0]), 64'd0);

        // Single instruction, 2x2, always ready.
        clear_log();
        drv(); in_valid[0] = 1; in_data[0] = 64'h1;
        step(); c0 = cyc - 1;
        drv(); in_valid[0] = 0;
        b = 0;
        while (cyc - 1 < c0 + 5 && b < 20) begin step(); b++; end
        chk("single busy at +5", 64'(busy[0]), 64'd0);
        chk("single uop count", 64'(lg_m.size()), 64'd4);
        for (int k = 0; k < 4 && k < lg_m.size(); k++) begin
            chk($sformatf("single uop%0d cycle", k), 64'(lg_cyc[k]), 64'(c0 + 1 + k));
            chk($sformatf("single uop%0d m", k), 64'(lg_m[k]), 64'(k % 2));
            chk($sformatf("single uop%0d n", k), 64'(lg_n[k]), 64'(k / 2));
            chk($sformatf("single uop%0d sop", k), 64'(lg_sop[k]), 64'(k == 0));
            chk($sformatf("single uop%0d eop", k), 64'(lg_eop[k]), 64'(k == 3));
        end

        // Back-to-back instructions with in_valid held.
        clear_log();
        base = in_fires[0];
        drv(); in_valid[0] = 1; in_data[0] = 64'hA;
        b = 0;
        while (in_fires[0] - base < 1 && b < 20) begin step(); b++; end
        drv(); in_data[0] = 64'hB;
        while (in_fires[0] - base < 2 && b < 40) begin step(); b++; end
        drv(); in_valid[0] = 0;
        wait_log(8, "b2b");
        chk("b2b uop count", 64'(lg_m.size()), 64'd8);
        if (lg_m.size() >= 8) begin
            chk("b2b no bubble", 64'(lg_cyc[7] - lg_cyc[0]), 64'd7);
            chk("b2b data uop4", lg_dat[3], 64'hA);
            chk("b2b data uop5", lg_dat[4], 64'hB);
            chk("b2b sop uop5", 64'(lg_sop[4]), 64'd1);
            chk("b2b eop uop4", 64'(lg_eop[3]), 64'd1);
        end
        repeat (2) step();

        // Stall three cycles on the second micro-op.
        clear_log();
        s0 = stall_obs[0];
`ifdef TCU_UOP_PERF_EN
        p0 = perf_stalls[0];
`endif
        drv(); in_valid[0] = 1; in_data[0] = 64'hC;
        step();
        drv(); in_valid[0] = 0;
        wait_log(1, "stall first");
        drv(); out_ready[0] = 0;
        repeat (3) @(posedge clk);
        #1 out_ready[0] = 1;
        wait_log(4, "stall rest");
        step();
        chk("stall cycles", 64'(stall_obs[0] - s0), 64'd3);
        chk("stall uop count", 64'(lg_m.size()), 64'd4);
        if (lg_m.size() >= 2) begin
            chk("stall uop2 m", 64'(lg_m[1]), 64'd1);
            chk("stall uop2 n", 64'(lg_n[1]), 64'd0);
            chk("stall uop2 delay", 64'(lg_cyc[1] - lg_cyc[0]), 64'd4);
        end
`ifdef TCU_UOP_PERF_EN
        chk("stall perf_stalls", 64'(perf_stalls[0] - p0), 64'd3);
`endif

        // Reset in the middle of an instruction.
        clear_log();
        drv(); in_valid[0] = 1; in_data[0] = 64'hD;
        step();
        drv(); in_valid[0] = 0;
        wait_log(2, "rst mid");
        drv(); reset[0] = 1;
        drv(); reset[0] = 0;
        step();
        chk("rst mid out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst mid in_ready", 64'(in_ready[0]), 64'd1);
        chk("rst mid sop", 64'(out_sop[0]), 64'd0);
        clear_log();
        drv(); in_valid[0] = 1; in_data[0] = 64'hE;
        step();
        drv(); in_valid[0] = 0;
        wait_log(4, "rst restart");
        step();
        chk("restart uop count", 64'(lg_m.size()), 64'd4);
        if (lg_m.size() >= 1) begin
            chk("restart data", lg_dat[0], 64'hE);
            chk("restart m", 64'(lg_m[0]), 64'd0);
            chk("restart n", 64'(lg_n[0]), 64'd0);
            chk("restart sop", 64'(lg_sop[0]), 64'd1);
        end

        // Random traffic on the 2x2 instance.
        for (int k = 0; k < 400; k++) begin
            drv();
            in_valid[0]  = 1'($urandom_range(0, 1));
            in_data[0]   = {$urandom, $urandom};
            out_ready[0] = ($urandom_range(0, 3) != 0);
        end
        drv(); in_valid[0] = 0; out_ready[0] = 1;
        repeat (8) step();
        chk("random drained", 64'(busy[0]), 64'd0);

        // 1x1 instance under continuous traffic.
        f0 = fires[1];
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            drv(); in_valid[1] = 1; in_data[1] = {$urandom, $urandom};
            step();
            if (!in_ready[1]) lows++;
        end
        drv(); in_valid[1] = 0;
        repeat (3) step();
        chk("1x1 in_ready low cycles", 64'(lows), 64'd0);
        chk("1x1 uop count", 64'(fires[1] - f0), 64'd20);

        // 16x16 instance, random 50% out_ready.
        f0 = fires[2];
        drv(); in_valid[2] = 1; in_data[2] = 64'h5A5A;
        step();
        drv(); in_valid[2] = 0;
        b = 0;
        while (fires[2] - f0 < 256 && b < 3000) begin
            drv(); out_ready[2] = 1'($urandom_range(0, 1));
            step();
            b++;
        end
        drv(); out_ready[2] = 1;
        repeat (2) step();
        chk("16x16 in time", 64'(b < 3000), 64'd1);
        chk("16x16 uop count", 64'(fires[2] - f0), 64'd256);
        chk("16x16 busy after", 64'(busy[2]), 64'd0);
`ifdef TCU_UOP_PERF_EN
        chk("16x16 perf_uops", 64'(perf_uops[2]), 64'd256);
        chk("16x16 perf_instrs", 64'(perf_instrs[2]), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
